// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for a 5-stage MIPS pipeline.
// Handles Decode-resolved redirects, hazard stalls and a halt-then-drain sequence.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        Stall_F,
    input  logic        Stall_D,
    input  logic        PCSrc_D,
    input  logic [31:0] PCBranch_D,
    input  logic        Jump_D,
    input  logic [31:0] PCJump_D,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PCPlus4_D,
    output logic        Halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pcplus4_q, pcplus4_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               redirect;
    logic               halt_detect;
    logic [31:0]        pc_plus4;
    logic [31:0]        next_pc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               drain_done;

    assign redirect    = Jump_D | PCSrc_D;
    assign pc_plus4    = pc_q + 32'd4;
    assign next_pc     = Jump_D  ? PCJump_D   :
                         PCSrc_D ? PCBranch_D : pc_plus4;
    // A halt word on a stalled or squashed fetch is not a real halt.
    assign halt_detect = (Instr_F == HALT_INSTR) && !Stall_D && !redirect;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign drain_done  = !Stall_D && (32'(cnt_inc) >= 32'(DRAIN_CYCLES));

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            pcplus4_q <= 32'h0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (halt_detect) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done)  state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Datapath next values and outputs
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (!Stall_F && !halt_detect) begin
                    pc_d = next_pc;
                end
                // A stalled Decode keeps its branch; it re-resolves next cycle.
                if (Stall_D) begin
                    instr_d   = instr_q;
                    pcplus4_d = pcplus4_q;
                end else if (redirect || halt_detect) begin
                    instr_d   = 32'h0;
                    pcplus4_d = 32'h0;
                end else begin
                    instr_d   = Instr_F;
                    pcplus4_d = pc_plus4;
                end
            end
            ST_DRAIN: begin
                if (!Stall_D) begin
                    instr_d   = 32'h0;
                    pcplus4_d = 32'h0;
                    cnt_d     = cnt_inc;
                end
            end
            ST_HALTED: begin
                instr_d   = 32'h0;
                pcplus4_d = 32'h0;
            end
            default: begin
                pc_d      = RESET_PC;
                instr_d   = 32'h0;
                pcplus4_d = 32'h0;
                cnt_d     = '0;
            end
        endcase
    end

    assign PC_F      = pc_q;
    assign Instr_D   = instr_q;
    assign PCPlus4_D = pcplus4_q;
    assign Halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential flow, stalls, redirects, halt/drain, reset and wrap.
module tb_fetch_stage;

    logic        CLK;
    logic        reset;
    logic        Stall_F;
    logic        Stall_D;
    logic        PCSrc_D;
    logic [31:0] PCBranch_D;
    logic        Jump_D;
    logic [31:0] PCJump_D;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PCPlus4_D;
    logic        Halted;

    logic        ovr_en;
    logic [31:0] ovr_val;

    int tests;
    int failed;

    fetch_stage dut (
        .CLK        (CLK),
        .reset      (reset),
        .Stall_F    (Stall_F),
        .Stall_D    (Stall_D),
        .PCSrc_D    (PCSrc_D),
        .PCBranch_D (PCBranch_D),
        .Jump_D     (Jump_D),
        .PCJump_D   (PCJump_D),
        .Instr_F    (Instr_F),
        .PC_F       (PC_F),
        .Instr_D    (Instr_D),
        .PCPlus4_D  (PCPlus4_D),
        .Halted     (Halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory model: each word tags its own address.
    assign Instr_F = ovr_en ? ovr_val : {8'hA5, PC_F[23:0]};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic h);
        chk({tag, ".PC_F"}, PC_F, pc);
        chk({tag, ".Instr_D"}, Instr_D, ins);
        chk({tag, ".PCPlus4_D"}, PCPlus4_D, p4);
        chk({tag, ".Halted"}, {31'h0, Halted}, {31'h0, h});
        $display("[TB] %s PC_F=%h Instr_D=%h PCPlus4_D=%h Halted=%0d", tag, PC_F, Instr_D, PCPlus4_D, Halted);
    endtask

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1; Stall_F = 1'b0; Stall_D = 1'b0;
        PCSrc_D = 1'b0; PCBranch_D = 32'h0; Jump_D = 1'b0; PCJump_D = 32'h0;
        ovr_en = 1'b0; ovr_val = 32'h0;
        #1;

        // 1. reset then sequential fetch
        step(); step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        step(); chk_all("seq1", 32'h4, 32'hA500_0000, 32'h4, 1'b0);
        step(); chk_all("seq2", 32'h8, 32'hA500_0004, 32'h8, 1'b0);

        // 2. stall both stages at PC_F=8
        Stall_F = 1'b1; Stall_D = 1'b1;
        step(); chk_all("stall", 32'h8, 32'hA500_0004, 32'h8, 1'b0);
        Stall_F = 1'b0; Stall_D = 1'b0;
        step(); chk_all("resume1", 32'hC, 32'hA500_0008, 32'hC, 1'b0);
        step(); chk_all("resume2", 32'h10, 32'hA500_000C, 32'h10, 1'b0);

        // 3. taken branch, then jump beating branch
        PCSrc_D = 1'b1; PCBranch_D = 32'h40;
        step(); chk_all("branch", 32'h40, 32'h0, 32'h0, 1'b0);
        PCSrc_D = 1'b0;
        step(); chk_all("after_br", 32'h44, 32'hA500_0040, 32'h44, 1'b0);
        Jump_D = 1'b1; PCJump_D = 32'h80; PCSrc_D = 1'b1; PCBranch_D = 32'h40;
        step(); chk_all("jump_prio", 32'h80, 32'h0, 32'h0, 1'b0);
        Jump_D = 1'b0; PCSrc_D = 1'b0;
        step(); chk_all("after_jmp", 32'h84, 32'hA500_0080, 32'h84, 1'b0);

        // 4. branch under stall is deferred
        PCSrc_D = 1'b1; PCBranch_D = 32'h100; Stall_F = 1'b1; Stall_D = 1'b1;
        step(); chk_all("br_stalled", 32'h84, 32'hA500_0080, 32'h84, 1'b0);
        Stall_F = 1'b0; Stall_D = 1'b0;
        step(); chk_all("br_late", 32'h100, 32'h0, 32'h0, 1'b0);

        // 5a. halt word on squashed path is ignored
        ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFF; PCBranch_D = 32'h20;
        step(); chk_all("halt_squash", 32'h20, 32'h0, 32'h0, 1'b0);
        PCSrc_D = 1'b0;

        // 5b. real halt at 0x20, then drain with one stalled cycle
        step(); chk_all("halt_det", 32'h20, 32'h0, 32'h0, 1'b0);
        ovr_en = 1'b0; Jump_D = 1'b1; PCJump_D = 32'h200;
        step(); chk_all("drain1", 32'h20, 32'h0, 32'h0, 1'b0);
        step(); chk_all("drain2", 32'h20, 32'h0, 32'h0, 1'b0);
        step(); chk_all("drain3", 32'h20, 32'h0, 32'h0, 1'b0);
        Stall_D = 1'b1;
        step(); chk_all("drain_stall", 32'h20, 32'h0, 32'h0, 1'b0);
        Stall_D = 1'b0;
        step(); chk_all("halted", 32'h20, 32'h0, 32'h0, 1'b1);
        Jump_D = 1'b0;
        step(); chk_all("halted_sticky", 32'h20, 32'h0, 32'h0, 1'b1);

        // 6. reset out of HALTED, then PC wrap
        reset = 1'b1;
        step(); chk_all("reset_halted", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        Jump_D = 1'b1; PCJump_D = 32'hFFFF_FFFC;
        step(); chk_all("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        Jump_D = 1'b0;
        step(); chk_all("wrap", 32'h0, 32'hA5FF_FFFC, 32'h0, 1'b0);
        step(); chk_all("post_wrap", 32'h4, 32'hA500_0000, 32'h4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
